// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchronised RX, mid-bit sampling, one-cycle VALID/FERR strobes.
// A stop bit sampled low parks the receiver until the line returns high.
module uart_rx_8n1 #(
   parameter int CLKS_PER_BIT = 103,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2,
   parameter int DATA_BITS    = 8
) (
   input  logic                 CLK,
   input  logic                 RESETN,
   input  logic                 RX,
   output logic [DATA_BITS-1:0] DATA,
   output logic                 VALID,
   output logic                 FERR,
   output logic                 BUSY
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CW-1:0] C_HALF_END = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] C_BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] C_LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   logic                 r_sync1;
   logic                 r_sync2;
   logic                 w_rxs;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CW-1:0]        r_cnt;
   logic [CW-1:0]        w_cnt_nxt;
   logic [BW-1:0]        r_bit;
   logic [BW-1:0]        w_bit_nxt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_ferr;
   logic                 r_busy;

   logic                 w_shift_en;
   logic                 w_load;
   logic                 w_valid_nxt;
   logic                 w_ferr_nxt;

   // Synchroniser resets to 1 so a reset never looks like a start edge.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= RX;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rxs = r_sync2;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_valid <= w_valid_nxt;
         r_ferr  <= w_ferr_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         if (w_load) begin
            r_data <= r_shift;
         end
      end
   end

   // Shift register is pure datapath; it is fully overwritten by every frame.
   always_ff @(posedge CLK) begin
      if (w_shift_en) begin
         r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_bit_nxt   = r_bit;
      w_shift_en  = 1'b0;
      w_load      = 1'b0;
      w_valid_nxt = 1'b0;
      w_ferr_nxt  = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            w_bit_nxt = '0;
            if (!w_rxs) begin
               w_state_nxt = S_START;
            end
         end

         S_START: begin
            if (r_cnt == C_HALF_END) begin
               w_cnt_nxt   = '0;
               w_state_nxt = w_rxs ? S_IDLE : S_DATA;
            end
         end

         S_DATA: begin
            if (r_cnt == C_BIT_END) begin
               w_cnt_nxt  = '0;
               w_shift_en = 1'b1;
               if (r_bit == C_LAST_BIT) begin
                  w_bit_nxt   = '0;
                  w_state_nxt = S_STOP;
               end else begin
                  w_bit_nxt = r_bit + 1'b1;
               end
            end
         end

         S_STOP: begin
            if (r_cnt == C_BIT_END) begin
               w_cnt_nxt = '0;
               if (w_rxs) begin
                  w_load      = 1'b1;
                  w_valid_nxt = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_ferr_nxt  = 1'b1;
                  w_state_nxt = S_WAIT_HIGH;
               end
            end
         end

         // Break or stuck-low line: wait for high before hunting for a start bit.
         S_WAIT_HIGH: begin
            w_cnt_nxt = '0;
            if (w_rxs) begin
               w_state_nxt = S_IDLE;
            end
         end

         default: begin
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign DATA  = r_data;
   assign VALID = r_valid;
   assign FERR  = r_ferr;
   assign BUSY  = r_busy;

endmodule
